// File: rtl/nn_request_scheduler.sv
// nn_request_scheduler: shares the boxcar_nn inference port between four
// push-button requesters and a periodic demo sweep. One inference is in
// flight at a time; the last completed result is held for the output logic.
module nn_request_scheduler #(
  parameter int WIDTH       = 16,
  parameter int FRAC_BITS   = 10,
  parameter int TICK_DIV    = 2_700_000,
  parameter int SWEEP_TICKS = 10,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       btn_i,
  input  logic             demo_en_i,
  output logic [WIDTH-1:0] nn_x_o,
  output logic             nn_start_o,
  input  logic             nn_valid_i,
  input  logic [WIDTH-1:0] nn_y_i,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] x_o,
  output logic [2:0]       src_o,
  output logic             result_valid_o,
  output logic             busy_o,
  output logic             timeout_o
);

  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SWP_W  = (SWEEP_TICKS > 1) ? $clog2(SWEEP_TICKS) : 1;

  // 1.0 in the fixed-point format; button and demo values are whole/half units
  localparam longint ONE_L = 64'sd1 <<< FRAC_BITS;
  localparam logic signed [WIDTH-1:0] DEMO_BASE_Q = WIDTH'(-3 * ONE_L);
  localparam logic signed [WIDTH-1:0] HALF_Q      = WIDTH'(ONE_L / 2);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t                  state_reg;
  logic [3:0]              btn_prev_reg;
  logic [3:0]              pend_btn_reg;
  logic                    pend_demo_reg;
  logic [TICK_W-1:0]       tick_reg;
  logic [SWP_W-1:0]        sweep_reg;
  logic [3:0]              idx_reg;
  logic signed [WIDTH-1:0] demo_x_reg;
  logic signed [WIDTH-1:0] cur_x_reg;
  logic [2:0]              cur_src_reg;
  logic [WD_W-1:0]         wdog_reg;
  logic [WIDTH-1:0]        y_reg;
  logic [WIDTH-1:0]        x_reg;
  logic [2:0]              src_reg;
  logic                    start_reg;
  logic                    rv_reg;
  logic                    busy_reg;
  logic                    timeout_reg;

  logic [4:0]              req;
  logic [4:0]              grant_oh;
  logic                    grant_any;
  logic                    tick_tc;
  logic signed [WIDTH-1:0] grant_x;
  logic [2:0]              grant_src;

  function automatic logic signed [WIDTH-1:0] btn_value(input logic [1:0] k);
    case (k)
      2'd0:    btn_value = WIDTH'(-2 * ONE_L);
      2'd1:    btn_value = WIDTH'(-1 * ONE_L);
      2'd2:    btn_value = WIDTH'(ONE_L);
      default: btn_value = WIDTH'(2 * ONE_L);
    endcase
  endfunction

  // Fixed priority: lowest set bit wins (btn0 highest, demo lowest), IDLE only
  assign req       = {pend_demo_reg, pend_btn_reg};
  assign grant_oh  = (state_reg == ST_IDLE) ? (req & (~req + 5'd1)) : 5'd0;
  assign grant_any = |grant_oh;
  assign tick_tc   = (tick_reg == TICK_W'(TICK_DIV - 1));

  // Value and source of the winning request
  always_comb begin
    grant_x   = demo_x_reg;
    grant_src = 3'd4;
    for (int k = 3; k >= 0; k--) begin
      if (pend_btn_reg[k]) begin
        grant_x   = btn_value(2'(k));
        grant_src = 3'(k);
      end
    end
  end

  // Button edge detect; an edge on an already-pending bit is absorbed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_prev_reg <= 4'd0;
      pend_btn_reg <= 4'd0;
    end else begin
      btn_prev_reg <= btn_i;
      pend_btn_reg <= (pend_btn_reg | (btn_i & ~btn_prev_reg)) & ~grant_oh[3:0];
    end
  end

  // Demo tick divider and demo pending bit; disabling drops any queued demo
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tick_reg      <= '0;
      pend_demo_reg <= 1'b0;
    end else if (!demo_en_i) begin
      tick_reg      <= '0;
      pend_demo_reg <= 1'b0;
    end else begin
      tick_reg      <= tick_tc ? '0 : tick_reg + 1'b1;
      pend_demo_reg <= (pend_demo_reg | tick_tc) & ~grant_oh[4];
    end
  end

  // Sweep position advances after every SWEEP_TICKS demo grants, wrapping 12 -> 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sweep_reg  <= '0;
      idx_reg    <= 4'd0;
      demo_x_reg <= DEMO_BASE_Q;
    end else if (grant_oh[4]) begin
      if (sweep_reg == SWP_W'(SWEEP_TICKS - 1)) begin
        sweep_reg <= '0;
        if (idx_reg == 4'd12) begin
          idx_reg    <= 4'd0;
          demo_x_reg <= DEMO_BASE_Q;
        end else begin
          idx_reg    <= idx_reg + 4'd1;
          demo_x_reg <= demo_x_reg + HALF_Q;
        end
      end else begin
        sweep_reg <= sweep_reg + 1'b1;
      end
    end
  end

  // Single-outstanding inference handshake with watchdog and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      cur_x_reg   <= '0;
      cur_src_reg <= 3'd0;
      wdog_reg    <= '0;
      y_reg       <= '0;
      x_reg       <= '0;
      src_reg     <= 3'd0;
      start_reg   <= 1'b0;
      rv_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      rv_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            cur_x_reg   <= grant_x;
            cur_src_reg <= grant_src;
            start_reg   <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wdog_reg  <= '0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (nn_valid_i) begin
            y_reg     <= nn_y_i;
            x_reg     <= cur_x_reg;
            src_reg   <= cur_src_reg;
            rv_reg    <= 1'b1;
            state_reg <= ST_DONE;
          end else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
            timeout_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= ST_IDLE;
          end else begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign nn_x_o         = cur_x_reg;
  assign nn_start_o     = start_reg;
  assign y_o            = y_reg;
  assign x_o            = x_reg;
  assign src_o          = src_reg;
  assign result_valid_o = rv_reg;
  assign busy_o         = busy_reg;
  assign timeout_o      = timeout_reg;

endmodule

// File: tb/tb_nn_request_scheduler.sv
// Testbench for nn_request_scheduler: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// request/job-level reference model.
module tb_nn_request_scheduler;

  localparam int W        = 16;
  localparam int TB_TICK  = 8;
  localparam int TB_SWEEP = 2;
  localparam int TB_TO    = 16;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   btn_i = 4'd0;
  logic         demo_en_i = 1'b0;
  logic [W-1:0] nn_x_o;
  logic         nn_start_o;
  logic         nn_valid_i;
  logic [W-1:0] nn_y_i;
  logic [W-1:0] y_o;
  logic [W-1:0] x_o;
  logic [2:0]   src_o;
  logic         result_valid_o;
  logic         busy_o;
  logic         timeout_o;

  nn_request_scheduler #(
    .WIDTH(W), .FRAC_BITS(10), .TICK_DIV(TB_TICK),
    .SWEEP_TICKS(TB_SWEEP), .TIMEOUT(TB_TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .btn_i(btn_i), .demo_en_i(demo_en_i),
    .nn_x_o(nn_x_o), .nn_start_o(nn_start_o), .nn_valid_i(nn_valid_i),
    .nn_y_i(nn_y_i), .y_o(y_o), .x_o(x_o), .src_o(src_o),
    .result_valid_o(result_valid_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (request/job level) ----------------
  int   BTN_X [4] = '{-2048, -1024, 1024, 2048};
  bit   m_pend [5];          // 0..3 buttons, 4 demo
  logic [3:0] m_prev;
  int   m_tick, m_gcnt, m_idx;
  bit   m_active, m_done;
  int   m_age;               // 1 = start cycle, >=2 waiting for result
  int   m_cur_x, m_cur_src;
  int   m_y, m_x, m_src;
  bit   m_to;
  logic [3:0] m_edges;
  bit   m_tc;
  int   m_g;

  initial begin
    forever begin
      @(posedge clk or posedge rst_i);
      if (rst_i) begin
        for (int k = 0; k < 5; k++) m_pend[k] = 0;
        m_prev = 4'd0; m_tick = 0; m_gcnt = 0; m_idx = 0;
        m_active = 0; m_done = 0; m_age = 0;
        m_cur_x = 0; m_cur_src = 0; m_y = 0; m_x = 0; m_src = 0; m_to = 0;
      end else begin
        m_edges = btn_i & ~m_prev;
        m_tc = demo_en_i && (m_tick == TB_TICK - 1);
        m_g = -1;
        if (m_done) begin
          m_done = 0;
          m_active = 0;
        end else if (m_active) begin
          if (m_age >= 2 && nn_valid_i) begin
            m_y = $signed(nn_y_i);
            m_x = m_cur_x;
            m_src = m_cur_src;
            m_done = 1;
          end else if (m_age == 1 + TB_TO) begin
            m_to = 1;
            m_active = 0;
          end else begin
            m_age++;
          end
        end else begin
          for (int k = 0; k < 5; k++) if (m_g < 0 && m_pend[k]) m_g = k;
          if (m_g >= 0) begin
            m_active = 1;
            m_age = 1;
            m_cur_src = m_g;
            if (m_g < 4) m_cur_x = BTN_X[m_g];
            else begin
              m_cur_x = -3072 + 512 * m_idx;
              m_gcnt++;
              if (m_gcnt == TB_SWEEP) begin
                m_gcnt = 0;
                m_idx = (m_idx + 1) % 13;
              end
            end
          end
        end
        for (int k = 0; k < 4; k++)
          m_pend[k] = (m_g == k) ? 1'b0 : (m_pend[k] | m_edges[k]);
        m_pend[4] = !demo_en_i ? 1'b0 : ((m_g == 4) ? 1'b0 : (m_pend[4] | m_tc));
        m_tick = demo_en_i ? (m_tick + 1) % TB_TICK : 0;
        m_prev = btn_i;
      end
    end
  end

  // ---------------- compare + transaction recorder ----------------
  int sx_q[$];   // x of every start pulse
  int sc_q[$];   // cycle of every start pulse
  int rs_q[$];   // src of every result
  int ry_q[$];   // y of every result
  int rc_q[$];   // cycle of every result

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (armed && !rst_i) begin
        chk("nn_start", nn_start_o, (m_active && !m_done && m_age == 1) ? 1 : 0);
        chk("busy", busy_o, m_active ? 1 : 0);
        chk("result_valid", result_valid_o, m_done ? 1 : 0);
        chk("nn_x", $signed(nn_x_o), m_cur_x);
        chk("y", $signed(y_o), m_y);
        chk("x", $signed(x_o), m_x);
        chk("src", src_o, m_src);
        chk("timeout", timeout_o, m_to ? 1 : 0);
        if (nn_start_o) begin
          sx_q.push_back($signed(nn_x_o));
          sc_q.push_back(cyc);
        end
        if (result_valid_o) begin
          rs_q.push_back(src_o);
          ry_q.push_back($signed(y_o));
          rc_q.push_back(cyc);
          $display("result src=%0d x=%0d y=%0d cyc=%0d", src_o, $signed(x_o), $signed(y_o), cyc);
        end
      end
    end
  end

  // ---------------- boxcar_nn stand-in ----------------
  int   rsp_cnt = 0;
  int   rsp_delay = 3;
  bit   rsp_never = 0;
  bit   rsp_rand = 0;
  bit   noise_en = 0;
  logic [W-1:0] rsp_x;

  initial begin
    nn_valid_i = 1'b0;
    nn_y_i = '0;
    forever begin
      @(negedge clk);
      nn_valid_i = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          nn_valid_i = 1'b1;
          nn_y_i = rsp_rand ? W'($urandom) : rsp_x;
        end
      end else if (noise_en && $urandom_range(0, 19) == 0) begin
        nn_valid_i = 1'b1;
        nn_y_i = W'($urandom);
      end
      if (nn_start_o === 1'b1 && !rst_i) begin
        rsp_x = nn_x_o;
        if (rsp_rand) begin
          if ($urandom_range(0, 9) != 0) rsp_cnt = $urandom_range(1, 6);
        end else if (!rsp_never) begin
          rsp_cnt = rsp_delay;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clrq();
    sx_q.delete(); sc_q.delete(); rs_q.delete(); ry_q.delete(); rc_q.delete();
  endtask

  task automatic pulse(input logic [3:0] b);
    btn_i = b;
    step();
    btn_i = 4'd0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 3 && n < 500) begin
      step();
      n++;
      q = busy_o ? 0 : q + 1;
    end
    chk("quiet_within_bound", (n < 500) ? 1 : 0, 1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (nn_start_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("start_seen", (nn_start_o === 1'b1) ? 1 : 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a;
    int dur;
    int all_demo;
    int n;
    step();
    step();
    step();
    rst_i = 1'b0;
    armed = 1;
    step();
    // reset state
    chk("rst_busy", busy_o, 0);
    chk("rst_y", y_o, 0);
    chk("rst_src", src_o, 0);
    chk("rst_nn_x", nn_x_o, 0);
    chk("rst_timeout", timeout_o, 0);

    // single button 2 request
    clrq();
    a = cyc;
    pulse(4'b0100);
    wait_quiet();
    chk("t1_starts", sx_q.size(), 1);
    if (sx_q.size() == 1) begin
      chk("t1_start_x", sx_q[0], 1024);
      chk("t1_start_latency", sc_q[0] - a, 2);
    end
    chk("t1_results", rs_q.size(), 1);
    if (rs_q.size() == 1 && sc_q.size() == 1) chk("t1_result_latency", rc_q[0] - sc_q[0], 4);
    chk("t1_y", $signed(y_o), 1024);
    chk("t1_src", src_o, 2);
    chk("t1_busy", busy_o, 0);

    // demo sweep
    do_reset();
    clrq();
    demo_en_i = 1'b1;
    repeat (240) step();
    demo_en_i = 1'b0;
    wait_quiet();
    chk("t2_enough_grants", (sx_q.size() >= 28) ? 1 : 0, 1);
    if (sx_q.size() >= 28) begin
      chk("t2_x0", sx_q[0], -3072);
      chk("t2_x1", sx_q[1], -3072);
      chk("t2_x2", sx_q[2], -2560);
      chk("t2_x3", sx_q[3], -2560);
      chk("t2_x24_idx12", sx_q[24], 3072);
      chk("t2_x26_wrap", sx_q[26], -3072);
    end
    all_demo = 1;
    foreach (rs_q[i]) if (rs_q[i] != 4) all_demo = 0;
    chk("t2_all_src_demo", all_demo, 1);

    // simultaneous btn0 + btn3 during a demo inference
    do_reset();
    clrq();
    demo_en_i = 1'b1;
    wait_start();
    demo_en_i = 1'b0;
    step();
    btn_i = 4'b1001;
    step();
    step();
    btn_i = 4'd0;
    wait_quiet();
    chk("t3_starts", sx_q.size(), 3);
    chk("t3_results", rs_q.size(), 3);
    if (sx_q.size() == 3 && rs_q.size() == 3) begin
      chk("t3_x_demo", sx_q[0], -3072);
      chk("t3_x_btn0", sx_q[1], -2048);
      chk("t3_x_btn3", sx_q[2], 2048);
      chk("t3_src0", rs_q[0], 4);
      chk("t3_src1", rs_q[1], 0);
      chk("t3_src2", rs_q[2], 3);
      chk("t3_b2b_gap1", sc_q[1] - sc_q[0], 6);
      chk("t3_b2b_gap2", sc_q[2] - sc_q[1], 6);
    end

    // btn1 toggled three times during one long wait -> one inference
    clrq();
    rsp_delay = 10;
    pulse(4'b0100);
    wait_start();
    for (int i = 0; i < 3; i++) begin
      btn_i = 4'b0010;
      step();
      btn_i = 4'd0;
      step();
    end
    wait_quiet();
    rsp_delay = 3;
    chk("t4_starts", sx_q.size(), 2);
    if (sx_q.size() == 2) begin
      chk("t4_x0", sx_q[0], 1024);
      chk("t4_x1", sx_q[1], -1024);
    end
    chk("t4_y", $signed(y_o), -1024);

    // watchdog timeout
    clrq();
    rsp_never = 1;
    pulse(4'b1000);
    wait_start();
    a = cyc;
    n = 0;
    while (busy_o && n < 100) begin
      step();
      n++;
    end
    dur = cyc - a;
    chk("t5_busy_span", dur, 1 + TB_TO);
    chk("t5_timeout", timeout_o, 1);
    chk("t5_y_kept", $signed(y_o), -1024);
    chk("t5_no_result", rs_q.size(), 0);
    rsp_never = 0;
    pulse(4'b0001);
    wait_quiet();
    chk("t5_next_y", $signed(y_o), -2048);
    chk("t5_next_src", src_o, 0);
    chk("t5_timeout_sticky", timeout_o, 1);
    chk("t5_next_results", rs_q.size(), 1);

    // asynchronous reset in WAIT
    pulse(4'b0100);
    wait_start();
    step();
    #2 rst_i = 1'b1;
    #1;
    chk("t6_busy", busy_o, 0);
    chk("t6_y", y_o, 0);
    chk("t6_x", x_o, 0);
    chk("t6_nn_x", nn_x_o, 0);
    chk("t6_src", src_o, 0);
    chk("t6_timeout", timeout_o, 0);
    chk("t6_start", nn_start_o, 0);
    chk("t6_rv", result_valid_o, 0);
    clrq();
    step();
    rst_i = 1'b0;
    repeat (10) step();
    chk("t6_late_valid_ignored", rs_q.size(), 0);
    chk("t6_y_after", y_o, 0);
    chk("t6_busy_after", busy_o, 0);

    // randomized traffic
    clrq();
    rsp_rand = 1;
    noise_en = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] flip;
      flip = 4'd0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) flip[b] = 1'b1;
      btn_i = btn_i ^ flip;
      if ($urandom_range(0, 59) == 0) demo_en_i = ~demo_en_i;
      step();
    end
    noise_en = 0;
    btn_i = 4'd0;
    demo_en_i = 1'b0;
    wait_quiet();
    rsp_rand = 0;
    chk("rand_results_seen", (rs_q.size() > 0) ? 1 : 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
